// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with a registered output stage and fixed-select
// or round-robin grant. Optional packet lock enabled by defining MUX_PKT_LOCK_EN.
module stream_mux_rr #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
`ifdef MUX_PKT_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_e;

  ostate_e          state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`ifdef MUX_PKT_LOCK_EN
  logic             locked_q, locked_d;
  logic [SEL_W-1:0] lock_chan_q, lock_chan_d;
  logic             last_q, last_d;
  logic             sel_last;
`endif

  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;
  logic             load;
  logic             xfer;

  // Wraps at CHANNELS-1 rather than at 2^SEL_W so the pointer never names a missing channel.
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] c);
    if (c >= SEL_W'(CHANNELS - 1)) return '0;
    return c + 1'b1;
  endfunction

  function automatic logic chan_bit(input logic [CHANNELS-1:0] v, input logic [SEL_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == SEL_W'(i)) b = v[i];
    end
    return b;
  endfunction

  always_comb begin
    logic [SEL_W-1:0] cand;
    grant     = '0;
    grant_vld = 1'b0;
    cand      = rr_ptr_q;
    if (!mode) begin
      grant     = sel;
      grant_vld = (sel <= SEL_W'(CHANNELS - 1));
    end
`ifdef MUX_PKT_LOCK_EN
    else if (locked_q) begin
      grant     = lock_chan_q;
      grant_vld = 1'b1;
    end
`endif
    else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (!grant_vld && chan_bit(in_valid, cand)) begin
          grant     = cand;
          grant_vld = 1'b1;
        end
        cand = wrap_inc(cand);
      end
    end
  end

  // in_ready is a pure function of the grant, never of the granted channel's own valid.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    in_ready  = '0;
`ifdef MUX_PKT_LOCK_EN
    sel_last  = 1'b0;
`endif
    load = (state_q == EMPTY) || out_ready;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_data  = in_data[i*WIDTH +: WIDTH];
        sel_valid = in_valid[i];
`ifdef MUX_PKT_LOCK_EN
        sel_last  = in_last[i];
`endif
        in_ready[i] = !rst && load && grant_vld;
      end
    end
    xfer = !rst && load && grant_vld && sel_valid;
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    chan_d   = chan_q;
    rr_ptr_d = rr_ptr_q;
`ifdef MUX_PKT_LOCK_EN
    locked_d    = locked_q;
    lock_chan_d = lock_chan_q;
    last_d      = last_q;
`endif
    if (xfer) begin
      state_d  = FULL;
      data_d   = sel_data;
      chan_d   = grant;
      rr_ptr_d = wrap_inc(grant);
`ifdef MUX_PKT_LOCK_EN
      last_d = sel_last;
      if (mode) begin
        locked_d    = !sel_last;
        lock_chan_d = grant;
      end
`endif
    end else if (load) begin
      state_d = EMPTY;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      chan_q   <= '0;
      rr_ptr_q <= '0;
`ifdef MUX_PKT_LOCK_EN
      locked_q    <= 1'b0;
      lock_chan_q <= '0;
      last_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef MUX_PKT_LOCK_EN
      locked_q    <= locked_d;
      lock_chan_q <= lock_chan_d;
      last_q      <= last_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;
`ifdef MUX_PKT_LOCK_EN
  assign out_last  = last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance checked against a
// spec-level model; the packet-lock scenario runs only with MUX_PKT_LOCK_EN.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_mode, a_ordy, a_ovalid;
  logic [1:0]  a_sel, a_ochan;
  logic [15:0] a_data;
  logic [3:0]  a_valid, a_ready, a_odata;

  logic        b_mode, b_ordy, b_ovalid;
  logic [1:0]  b_sel, b_ochan;
  logic [11:0] b_data;
  logic [2:0]  b_valid, b_ready;
  logic [3:0]  b_odata;

`ifdef MUX_PKT_LOCK_EN
  logic [3:0] a_last;
  logic [2:0] b_last;
  logic       a_olast, b_olast;
`endif

  stream_mux_rr u_a (
    .clk(clk), .rst(rst), .mode(a_mode), .sel(a_sel),
    .in_data(a_data), .in_valid(a_valid),
`ifdef MUX_PKT_LOCK_EN
    .in_last(a_last), .out_last(a_olast),
`endif
    .in_ready(a_ready), .out_data(a_odata), .out_chan(a_ochan),
    .out_valid(a_ovalid), .out_ready(a_ordy)
  );

  stream_mux_rr #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) u_b (
    .clk(clk), .rst(rst), .mode(b_mode), .sel(b_sel),
    .in_data(b_data), .in_valid(b_valid),
`ifdef MUX_PKT_LOCK_EN
    .in_last(b_last), .out_last(b_olast),
`endif
    .in_ready(b_ready), .out_data(b_odata), .out_chan(b_ochan),
    .out_valid(b_ovalid), .out_ready(b_ordy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: what each output register should hold, plus arbiter state.
  int m_n [2] = '{4, 3};
  bit m_ov [2];
  int m_od [2];
  int m_oc [2];
  int m_ptr[2];
  bit m_lk [2];
  int m_lc [2];
  bit m_ol [2];

  function automatic bit in_mode(int id);
    return (id == 0) ? a_mode : b_mode;
  endfunction
  function automatic int in_sel(int id);
    return (id == 0) ? int'(a_sel) : int'(b_sel);
  endfunction
  function automatic bit in_ordy(int id);
    return (id == 0) ? a_ordy : b_ordy;
  endfunction
  function automatic bit in_v(int id, int c);
    return (id == 0) ? a_valid[c] : b_valid[c];
  endfunction
  function automatic int in_d(int id, int c);
    return (id == 0) ? int'(a_data[c*4 +: 4]) : int'(b_data[c*4 +: 4]);
  endfunction
  function automatic bit in_l(int id, int c);
`ifdef MUX_PKT_LOCK_EN
    return (id == 0) ? a_last[c] : b_last[c];
`else
    return (id == c) && 1'b0;
`endif
  endfunction

  // Granted channel, or -1 when nothing is granted.
  function automatic int f_grant(int id);
    int n = m_n[id];
    if (!in_mode(id)) return (in_sel(id) < n) ? in_sel(id) : -1;
    if (m_lk[id]) return m_lc[id];
    for (int k = 0; k < n; k++)
      if (in_v(id, (m_ptr[id] + k) % n)) return (m_ptr[id] + k) % n;
    return -1;
  endfunction

  function automatic int f_ready(int id);
    int g;
    bit load;
    if (rst) return 0;
    load = !m_ov[id] || in_ordy(id);
    g = f_grant(id);
    return (load && g >= 0) ? (1 << g) : 0;
  endfunction

  task automatic model_commit();
    for (int id = 0; id < 2; id++) begin
      int g;
      bit load;
      if (rst) begin
        m_ov[id] = 0; m_od[id] = 0; m_oc[id] = 0; m_ptr[id] = 0;
        m_lk[id] = 0; m_lc[id] = 0; m_ol[id] = 0;
      end else begin
        load = !m_ov[id] || in_ordy(id);
        g = f_grant(id);
        if (load && g >= 0 && in_v(id, g)) begin
          m_ov[id] = 1; m_od[id] = in_d(id, g); m_oc[id] = g;
          m_ol[id] = in_l(id, g);
          m_ptr[id] = (g + 1) % m_n[id];
`ifdef MUX_PKT_LOCK_EN
          if (in_mode(id)) begin
            m_lk[id] = !in_l(id, g);
            m_lc[id] = g;
          end
`endif
        end else if (load) begin
          m_ov[id] = 0;
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_all();
    a_mode = 1; a_sel = 0; a_data = 0; a_valid = 0; a_ordy = 1;
    b_mode = 1; b_sel = 0; b_data = 0; b_valid = 0; b_ordy = 1;
`ifdef MUX_PKT_LOCK_EN
    a_last = '1; b_last = '1;
`endif
  endtask

  task automatic do_reset(int n);
    rst = 1;
    repeat (n) begin settle(); advance(); end
    rst = 0;
  endtask

  task automatic test_reset();
    idle_all();
    a_valid = 4'hF; b_valid = 3'h7;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (a_ready !== 4'b0000) begin errors++; $display("FAIL reset_a_ready got %b want 0000", a_ready); end
      checks++;
      if (b_ready !== 3'b000) begin errors++; $display("FAIL reset_b_ready got %b want 000", b_ready); end
      advance();
    end
    checks++;
    if (a_ovalid !== 1'b0 || a_odata !== 4'h0 || a_ochan !== 2'd0) begin
      errors++; $display("FAIL reset_a_out got v=%b d=%h c=%0d want v=0 d=0 c=0", a_ovalid, a_odata, a_ochan);
    end
    rst = 0;
    settle();
    checks++;
    if (a_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", a_ready); end
    advance();
    checks++;
    if (a_ovalid !== 1'b1 || a_ochan !== 2'd0) begin
      errors++; $display("FAIL reset_first_beat got v=%b c=%0d want v=1 c=0", a_ovalid, a_ochan);
    end
    a_valid = 0; b_valid = 0;
    settle(); advance();
  endtask

  task automatic test_fixed();
    a_mode = 0; a_sel = 2; a_ordy = 1;
    for (int i = 0; i < 4; i++) begin
      a_valid = 4'($urandom) | 4'b0100;
      a_data = 16'($urandom);
      a_data[11:8] = 4'h5;
      settle();
      checks++;
      if (a_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready got %b want 0100", a_ready); end
      advance();
      checks++;
      if (a_ovalid !== 1'b1 || a_odata !== 4'h5 || a_ochan !== 2'd2) begin
        errors++; $display("FAIL fixed_out got v=%b d=%h c=%0d want v=1 d=5 c=2", a_ovalid, a_odata, a_ochan);
      end
    end
    a_valid = 0;
  endtask

  task automatic test_round_robin();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    idle_all();
    do_reset(1);
    a_mode = 1; a_valid = 4'hF; a_ordy = 1;
    for (int i = 0; i < 6; i++) begin
      a_data = 16'($urandom);
      settle();
      advance();
      checks++;
      if (a_ochan !== 2'(exp_seq[i]) || a_odata !== 4'(m_od[0])) begin
        errors++; $display("FAIL rr_seq[%0d] got c=%0d d=%h want c=%0d d=%h", i, a_ochan, a_odata, exp_seq[i], m_od[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] held;
    held = a_odata;
    a_ordy = 0;
    for (int i = 0; i < 3; i++) begin
      a_data = 16'($urandom);
      settle();
      checks++;
      if (a_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready got %b want 0000", a_ready); end
      advance();
      checks++;
      if (a_ovalid !== 1'b1 || a_odata !== held) begin
        errors++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=%h", a_ovalid, a_odata, held);
      end
    end
    a_ordy = 1;
    settle();
    checks++;
    if (a_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b want 0100", a_ready); end
    advance();
    checks++;
    if (a_ochan !== 2'd2 || a_odata !== 4'(m_od[0])) begin
      errors++; $display("FAIL bp_release_out got c=%0d d=%h want c=2 d=%h", a_ochan, a_odata, m_od[0]);
    end
    a_valid = 0;
    settle(); advance();
  endtask

  task automatic test_wrap_sparse();
    int exp_seq[4] = '{2, 0, 2, 0};
    idle_all();
    do_reset(1);
    b_valid = 3'b010;
    settle(); advance();
    b_valid = 3'b101;
    for (int i = 0; i < 4; i++) begin
      b_data = 12'($urandom);
      settle();
      advance();
      checks++;
      if (b_ochan !== 2'(exp_seq[i]) || b_odata !== 4'(m_od[1])) begin
        errors++; $display("FAIL wrap_seq[%0d] got c=%0d d=%h want c=%0d d=%h", i, b_ochan, b_odata, exp_seq[i], m_od[1]);
      end
    end
    b_mode = 0; b_sel = 3; b_valid = 3'b111;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (b_ready !== 3'b000) begin errors++; $display("FAIL sel_oob_ready got %b want 000", b_ready); end
      advance();
    end
    checks++;
    if (b_ovalid !== 1'b0) begin errors++; $display("FAIL sel_oob_drain got v=%b want 0", b_ovalid); end
    idle_all();
  endtask

`ifdef MUX_PKT_LOCK_EN
  task automatic test_pkt_lock();
    int exp_c[4] = '{1, 1, 1, 2};
    idle_all();
    do_reset(1);
    a_mode = 1; a_valid = 4'b0110; a_last = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      a_last[1] = (i == 2);
      if (i == 3) a_valid = 4'b0100;
      settle();
      if (i == 1 || i == 2) begin
        checks++;
        if (a_ready !== 4'b0010) begin errors++; $display("FAIL lock_ready[%0d] got %b want 0010", i, a_ready); end
      end
      advance();
      checks++;
      if (a_ochan !== 2'(exp_c[i]) || (i < 3 && a_olast !== (i == 2))) begin
        errors++; $display("FAIL lock_seq[%0d] got c=%0d last=%b want c=%0d last=%b", i, a_ochan, a_olast, exp_c[i], (i == 2));
      end
    end
    idle_all();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      a_mode = ($urandom_range(0, 3) != 0); a_sel = 2'($urandom);
      a_valid = 4'($urandom); a_data = 16'($urandom); a_ordy = ($urandom_range(0, 3) != 0);
      b_mode = ($urandom_range(0, 3) != 0); b_sel = 2'($urandom);
      b_valid = 3'($urandom); b_data = 12'($urandom); b_ordy = ($urandom_range(0, 3) != 0);
`ifdef MUX_PKT_LOCK_EN
      a_last = 4'($urandom); b_last = 3'($urandom);
`endif
      settle();
      checks++;
      if (a_ready !== 4'(f_ready(0))) begin errors++; $display("FAIL rand_a_ready[%0d] got %b want %b", i, a_ready, 4'(f_ready(0))); end
      checks++;
      if (b_ready !== 3'(f_ready(1))) begin errors++; $display("FAIL rand_b_ready[%0d] got %b want %b", i, b_ready, 3'(f_ready(1))); end
      advance();
      checks++;
      if (a_ovalid !== m_ov[0] || (m_ov[0] && (a_odata !== 4'(m_od[0]) || a_ochan !== 2'(m_oc[0])))) begin
        errors++; $display("FAIL rand_a_out[%0d] got v=%b d=%h c=%0d want v=%b d=%h c=%0d", i, a_ovalid, a_odata, a_ochan, m_ov[0], m_od[0], m_oc[0]);
      end
      checks++;
      if (b_ovalid !== m_ov[1] || (m_ov[1] && (b_odata !== 4'(m_od[1]) || b_ochan !== 2'(m_oc[1])))) begin
        errors++; $display("FAIL rand_b_out[%0d] got v=%b d=%h c=%0d want v=%b d=%h c=%0d", i, b_ovalid, b_odata, b_ochan, m_ov[1], m_od[1], m_oc[1]);
      end
`ifdef MUX_PKT_LOCK_EN
      checks++;
      if (m_ov[0] && a_olast !== m_ol[0]) begin errors++; $display("FAIL rand_a_last[%0d] got %b want %b", i, a_olast, m_ol[0]); end
`endif
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_all();
    for (int id = 0; id < 2; id++) begin
      m_ov[id] = 0; m_od[id] = 0; m_oc[id] = 0; m_ptr[id] = 0;
      m_lk[id] = 0; m_lc[id] = 0; m_ol[id] = 0;
    end
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_wrap_sparse();
`ifdef MUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with a valid/ready handshake on every input and on the output, and a registered output stage. Channel selection is either a fixed select input or a round-robin arbiter. It replaces the combinational 4-to-1 case mux wherever the inputs are producers that can stall and the consumer can apply backpressure.

## Interface
- `WIDTH`, default 4: data bits per channel.
- `CHANNELS`, default 4: number of input channels, 2..16.
- `SEL_W`, default 2: select/channel-index width; must satisfy 2^SEL_W >= CHANNELS.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `mode`, input, 1: 0 = fixed select, 1 = round-robin.
- `sel`, input, SEL_W: channel used when `mode`=0.
- `in_data`, input, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`, input, CHANNELS: per-channel valid.
- `in_ready`, output, CHANNELS: per-channel ready; one-hot or zero.
- `out_data`, output, WIDTH: registered data.
- `out_chan`, output, SEL_W: index of the source channel of `out_data`.
- `out_valid`, output, 1: output register holds a beat.
- `out_ready`, input, 1: consumer accepts the beat.
- `in_last` (input, CHANNELS) and `out_last` (output, 1): present only with `MUX_PKT_LOCK_EN`.

## Operation
- Output register states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `load` = EMPTY or (FULL and `out_ready`). A beat transfers from channel g when `load`, `in_valid[g]`, and g is granted.
- `in_ready[g]` = `load` and g is the granted channel. A channel's `in_ready` does not depend on its own `in_valid`.
- Fixed mode: grant = `sel`. If `sel` >= CHANNELS, nothing is granted and all `in_ready` = 0.
- Round-robin mode:
  - `rr_ptr` (SEL_W bits) names the highest-priority channel.
  - Grant goes to the first valid channel scanning `rr_ptr`, `rr_ptr`+1, …, wrapping modulo CHANNELS.
  - After a transfer from channel g, `rr_ptr` becomes (g+1) mod CHANNELS. The wrap from CHANNELS-1 goes to 0, not to 2^SEL_W.
  - With no transfer, `rr_ptr` holds.
- On a transfer:
  - `out_data` ← the granted slice.
  - `out_chan` ← g.
  - `out_valid` ← 1.
- If FULL, `out_ready`=1 and no valid granted input, `out_valid` ← 0 (drain).
- If FULL and `out_ready`=0, all output registers hold and all `in_ready` = 0.
- A `mode` or `sel` change takes effect on the next grant evaluation. A beat already in the output register is unaffected.
- Reset: `out_valid`=0, `out_data`=0, `out_chan`=0, `rr_ptr`=0, lock cleared. `in_ready` is forced to 0 during the reset cycle. Reset mid-stream discards the held beat.

## Timing
- Latency: input transfer at edge k → `out_valid`/`out_data` visible after edge k.
- Full throughput: one beat per cycle while `out_ready`=1.
- Combinational paths:
  - `in_ready` depends combinationally on `out_ready`, `out_valid`, `mode`, `sel`, `in_valid`, `rr_ptr` and the lock state.
  - There is no combinational path from `in_data` to `out_data`.
- `out_valid` never drops while `out_ready`=0. `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `MUX_PKT_LOCK_EN` defined:
  - Adds the `in_last`/`out_last` ports and a `locked` flag plus a `lock_chan` register.
  - Round-robin: after a transfer with `in_last[g]`=0, grant is locked to g until a beat with `in_last[g]`=1 transfers. Other channels get no `in_ready`, even if g is idle.
  - `out_last` is registered with `out_data`.
  - Fixed mode ignores the lock.
- `MUX_PKT_LOCK_EN` not defined: each beat is arbitrated independently and the last ports do not exist.

## Test plan
- Reset: assert `rst` with all `in_valid`=1 → `out_valid`=0, `out_data`=0, all `in_ready`=0. After release, round-robin grants channel 0 first.
- Fixed mode, `sel`=2, `in_data` slice2=4'h5, `out_ready`=1 → `out_data`=4'h5 and `out_chan`=2 one cycle later. `in_ready`=4'b0100 throughout.
- Round-robin, all valid, `out_ready`=1 for 6 cycles → `out_chan` sequence 0,1,2,3,0,1.
- Backpressure: hold `out_ready`=0 for 3 cycles with FULL → `out_data` stable, `in_ready`=0. Release → the next beat loads on the first cycle.
- Wrap and sparse: CHANNELS=3, SEL_W=2, only channels 2 and 0 valid, `rr_ptr`=2 → grants 2,0,2,0. `rr_ptr` never equals 3. `sel`=3 in fixed mode → no `in_ready`.
- `MUX_PKT_LOCK_EN`: channel 1 sends 3 beats with `in_last`=0,0,1 while channel 2 is valid → `out_chan`=1,1,1,2 and `out_last`=0,0,1,x.
